// File: rtl/des_stream_pkg.sv
// Shared definitions for the DES output byte stream.
//   BLOCK_W/BYTE_W/BYTES_PER_BLOCK : block and byte geometry
//   ser_state_t                    : serializer FSM states
//   block_byte()                   : byte k of a block, MSB first
package des_stream_pkg;

  localparam int unsigned BLOCK_W         = 64;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned BYTES_PER_BLOCK = 8;
  localparam int unsigned IDX_W           = $clog2(BYTES_PER_BLOCK);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Byte k is blk[63-8k -: 8]: shift the wanted byte to the top and take it.
  function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [IDX_W-1:0]   k);
    logic [BLOCK_W-1:0] sh;
    sh = blk << {k, 3'b000};
    return sh[BLOCK_W-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/des_block_serializer_if.sv
// Byte stream valid/ready handshake.
//   byte_data  : current byte
//   byte_valid : byte_data valid
//   byte_ready : sink accepts byte this cycle
//   byte_last  : final byte of a block
interface des_block_serializer_if;
  import des_stream_pkg::*;

  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_last;

  modport master (output byte_data, output byte_valid, output byte_last, input byte_ready);
  modport slave  (input byte_data, input byte_valid, input byte_last, output byte_ready);

endinterface

// File: rtl/des_block_fifo.sv
// DEPTH x 64 synchronous block FIFO, combinational head read.
//   clk, rst     : clock, synchronous active-high reset
//   push, wdata  : write request and block
//   pop, rdata   : read request and head block
//   count        : occupancy ($clog2(DEPTH)+1 bits)
//   full, empty  : occupancy flags
module des_block_fifo
  import des_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BLOCK_W-1:0]       wdata,
  output logic [BLOCK_W-1:0]       rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               do_push;
  logic               do_pop;

  // A push while full is accepted only if the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rptr];

  // Storage: no reset needed, occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/des_block_serializer.sv
// Captures completed triple-DES blocks on the rising edge of done, buffers
// them and streams each one out as 8 bytes, MSB first.
//   clk, rst          : clock, synchronous active-high reset
//   done              : block-complete strobe (may be held)
//   output_data_block : block to capture while done is high
//   byte_if           : byte stream (master side)
//   stall             : FIFO full, controller must hold off the core
//   empty             : nothing buffered and no byte pending
//   overflow          : sticky, a block was dropped
module des_block_serializer
  import des_stream_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done,
  input  logic [BLOCK_W-1:0]      output_data_block,
  des_block_serializer_if.master  byte_if,
  output logic                    stall,
  output logic                    empty,
  output logic                    overflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

  ser_state_t          state;
  logic [IDX_W-1:0]    idx;
  logic                valid_q;
  logic                done_q;

  logic                capture_c;
  logic                xfer_c;
  logic                pop_c;
  logic [BLOCK_W-1:0]  head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;

  assign capture_c = done & ~done_q;
  assign xfer_c    = valid_q & byte_if.byte_ready;
  assign pop_c     = xfer_c & (idx == LAST_IDX);

  des_block_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture_c),
    .pop   (pop_c),
    .wdata (output_data_block),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Byte mux is driven from flops only; held stable until the transfer.
  assign byte_if.byte_valid = valid_q;
  assign byte_if.byte_data  = valid_q ? block_byte(head, idx) : '0;
  assign byte_if.byte_last  = valid_q & (idx == LAST_IDX);

  assign stall = fifo_full;
  assign empty = fifo_empty;

  // Edge detect, sticky overflow and the byte-sending FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done_q <= done;
      if (capture_c & fifo_full & ~pop_c) overflow <= 1'b1;

      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state   <= SEND;
            valid_q <= 1'b1;
            idx     <= '0;
          end
        end
        SEND: begin
          if (xfer_c) begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              // Another block remains if one is behind the head or arrives now.
              if ((fifo_count > CNT_W'(1)) || capture_c) begin
                state   <= SEND;
                valid_q <= 1'b1;
              end else begin
                state   <= IDLE;
                valid_q <= 1'b0;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_serializer.sv
// Scoreboard bench for des_block_serializer (DEPTH = 2).
module tb_des_block_serializer;

  localparam int unsigned DEPTH = 2;

  localparam logic [63:0] BLK_T = 64'h81C28058B7764C21;
  localparam logic [63:0] BLK_A = 64'h0123456789ABCDEF;
  localparam logic [63:0] BLK_B = 64'hFEDCBA9876543210;
  localparam logic [63:0] BLK_C = 64'h0F1E2D3C4B5A6978;
  localparam logic [63:0] BLK_D = 64'h5566778899AABBCC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [63:0] blk = '0;
  logic        stall;
  logic        empty;
  logic        overflow;

  des_block_serializer_if bif();

  des_block_serializer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .done              (done),
    .output_data_block (blk),
    .byte_if           (bif),
    .stall             (stall),
    .empty             (empty),
    .overflow          (overflow)
  );

  always #5 clk = ~clk;

  logic [8:0] sb [$];
  int checks = 0;
  int passes = 0;
  int xfers  = 0;

  function automatic logic [7:0] tb_byte(input logic [63:0] b, input int k);
    return b[63-8*k -: 8];
  endfunction

  task automatic push_exp(input logic [63:0] b);
    for (int k = 0; k < 8; k++) sb.push_back({(k == 7), tb_byte(b, k)});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle done pulse followed by one low cycle.
  task automatic capture(input logic [63:0] b, input bit accept);
    if (accept) push_exp(b);
    blk  = b;
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || bif.byte_valid !== 1'b0) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (n >= budget) $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", sb.size(), budget);
    else passes++;
  endtask

  // Monitor: transfers against the scoreboard, hold stability, idle data.
  initial begin
    logic       stalled_prev;
    logic [7:0] held_data;
    logic       held_last;
    logic [8:0] exp_v;
    stalled_prev = 1'b0;
    held_data    = '0;
    held_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          checks++;
          if (bif.byte_valid !== 1'b1 || bif.byte_data !== held_data || bif.byte_last !== held_last)
            $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                     bif.byte_valid, bif.byte_data, bif.byte_last, held_data, held_last);
          else passes++;
        end
        if (bif.byte_valid === 1'b0) begin
          checks++;
          if (bif.byte_data !== 8'h00) $display("FAIL idle_data: data=%h, required 00", bif.byte_data);
          else passes++;
        end
        if (bif.byte_valid === 1'b1 && bif.byte_ready === 1'b1) begin
          xfers++;
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL unexpected_byte: got last=%b data=%h, required no transfer", bif.byte_last, bif.byte_data);
          end else begin
            exp_v = sb.pop_front();
            if ({bif.byte_last, bif.byte_data} !== exp_v)
              $display("FAIL byte: got last=%b data=%h, required last=%b data=%h",
                       bif.byte_last, bif.byte_data, exp_v[8], exp_v[7:0]);
            else passes++;
          end
        end
        stalled_prev = (bif.byte_valid === 1'b1) && (bif.byte_ready !== 1'b1);
        held_data    = bif.byte_data;
        held_last    = bif.byte_last;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    done = 1'b0;
    bif.byte_ready = 1'b0;
    cyc();
    cyc();
    checks += 6;
    if (bif.byte_valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", bif.byte_valid); else passes++;
    if (bif.byte_data !== 8'h00) $display("FAIL reset_data: got %h, required 00", bif.byte_data); else passes++;
    if (bif.byte_last !== 1'b0) $display("FAIL reset_last: got %b, required 0", bif.byte_last); else passes++;
    if (stall !== 1'b0) $display("FAIL reset_stall: got %b, required 0", stall); else passes++;
    if (empty !== 1'b1) $display("FAIL reset_empty: got %b, required 1", empty); else passes++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b, required 0", overflow); else passes++;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    int x0;
    bif.byte_ready = 1'b1;
    x0 = xfers;
    push_exp(BLK_T);
    blk  = BLK_T;
    done = 1'b1;
    cyc();
    done = 1'b0;
    checks += 2;
    if (bif.byte_valid !== 1'b0) $display("FAIL single_capture_valid: got %b, required 0", bif.byte_valid); else passes++;
    if (empty !== 1'b0) $display("FAIL single_capture_empty: got %b, required 0", empty); else passes++;
    cyc();
    checks += 2;
    if (bif.byte_valid !== 1'b1) $display("FAIL single_latency_valid: got %b, required 1", bif.byte_valid); else passes++;
    if (bif.byte_data !== 8'h81) $display("FAIL single_first_byte: got %h, required 81", bif.byte_data); else passes++;
    for (int i = 0; i < 8; i++) cyc();
    checks += 3;
    if (xfers - x0 != 8) $display("FAIL single_count: got %0d bytes in 8 cycles, required 8", xfers - x0); else passes++;
    if (bif.byte_valid !== 1'b0) $display("FAIL single_end_valid: got %b, required 0", bif.byte_valid); else passes++;
    if (empty !== 1'b1) $display("FAIL single_end_empty: got %b, required 1", empty); else passes++;
  endtask

  task automatic test_held_done();
    int x0;
    bif.byte_ready = 1'b1;
    x0 = xfers;
    push_exp(BLK_C);
    blk  = BLK_C;
    done = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    done = 1'b0;
    wait_idle(40);
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (xfers - x0 != 8) $display("FAIL held_done_count: got %0d bytes, required 8", xfers - x0); else passes++;
  endtask

  task automatic test_backpressure();
    bit pat [4];
    int x0;
    int n;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    x0 = xfers;
    bif.byte_ready = 1'b0;
    capture(BLK_D, 1'b1);
    n = 0;
    while ((sb.size() != 0 || bif.byte_valid !== 1'b0) && n < 100) begin
      bif.byte_ready = pat[n % 4];
      cyc();
      n++;
    end
    bif.byte_ready = 1'b1;
    checks += 2;
    if (n >= 100) $display("FAIL backpressure_timeout: %0d bytes still expected", sb.size()); else passes++;
    if (xfers - x0 != 8) $display("FAIL backpressure_count: got %0d bytes, required 8", xfers - x0); else passes++;
  endtask

  task automatic test_fill();
    int x0;
    x0 = xfers;
    bif.byte_ready = 1'b0;
    capture(BLK_A, 1'b1);
    capture(BLK_B, 1'b1);
    checks += 2;
    if (stall !== 1'b1) $display("FAIL fill_stall: got %b, required 1", stall); else passes++;
    if (overflow !== 1'b0) $display("FAIL fill_no_overflow: got %b, required 0", overflow); else passes++;
    capture(BLK_C, 1'b0);
    checks += 2;
    if (overflow !== 1'b1) $display("FAIL fill_overflow: got %b, required 1", overflow); else passes++;
    if (stall !== 1'b1) $display("FAIL fill_stall_after_drop: got %b, required 1", stall); else passes++;
    bif.byte_ready = 1'b1;
    wait_idle(60);
    for (int i = 0; i < 3; i++) cyc();
    checks += 3;
    if (xfers - x0 != 16) $display("FAIL fill_count: got %0d bytes, required 16", xfers - x0); else passes++;
    if (empty !== 1'b1) $display("FAIL fill_empty: got %b, required 1", empty); else passes++;
    if (overflow !== 1'b1) $display("FAIL fill_overflow_sticky: got %b, required 1", overflow); else passes++;
  endtask

  task automatic test_full_pop();
    int x0;
    int n;
    rst = 1'b1;
    sb.delete();
    cyc();
    rst = 1'b0;
    checks++;
    if (overflow !== 1'b0) $display("FAIL fullpop_reset_overflow: got %b, required 0", overflow); else passes++;
    x0 = xfers;
    bif.byte_ready = 1'b0;
    capture(BLK_A, 1'b1);
    capture(BLK_B, 1'b1);
    bif.byte_ready = 1'b1;
    n = 0;
    while (xfers - x0 < 8 && n < 50) begin cyc(); n++; end
    bif.byte_ready = 1'b0;
    capture(BLK_C, 1'b1);
    checks++;
    if (stall !== 1'b1) $display("FAIL fullpop_stall: got %b, required 1", stall); else passes++;
    bif.byte_ready = 1'b1;
    n = 0;
    while (!(xfers - x0 == 15 && bif.byte_last === 1'b1) && n < 50) begin cyc(); n++; end
    checks++;
    if (n >= 50) $display("FAIL fullpop_align_timeout: %0d bytes after %0d cycles, required 15", xfers - x0, n); else passes++;
    push_exp(BLK_D);
    blk  = BLK_D;
    done = 1'b1;
    cyc();
    done = 1'b0;
    checks += 4;
    if (overflow !== 1'b0) $display("FAIL fullpop_overflow: got %b, required 0", overflow); else passes++;
    if (stall !== 1'b1) $display("FAIL fullpop_stall_kept: got %b, required 1", stall); else passes++;
    if (bif.byte_valid !== 1'b1) $display("FAIL fullpop_no_gap: got valid %b, required 1", bif.byte_valid); else passes++;
    if (bif.byte_data !== 8'h0F) $display("FAIL fullpop_next_byte: got %h, required 0f", bif.byte_data); else passes++;
    wait_idle(60);
    for (int i = 0; i < 3; i++) cyc();
    checks += 2;
    if (xfers - x0 != 32) $display("FAIL fullpop_count: got %0d bytes, required 32", xfers - x0); else passes++;
    if (empty !== 1'b1) $display("FAIL fullpop_empty: got %b, required 1", empty); else passes++;
  endtask

  task automatic test_reset_mid();
    int x0;
    int n;
    bif.byte_ready = 1'b1;
    x0 = xfers;
    push_exp(BLK_A);
    blk  = BLK_A;
    done = 1'b1;
    cyc();
    done = 1'b0;
    n = 0;
    while (xfers - x0 < 3 && n < 20) begin cyc(); n++; end
    rst = 1'b1;
    sb.delete();
    cyc();
    checks += 5;
    if (bif.byte_valid !== 1'b0) $display("FAIL midreset_valid: got %b, required 0", bif.byte_valid); else passes++;
    if (bif.byte_data !== 8'h00) $display("FAIL midreset_data: got %h, required 00", bif.byte_data); else passes++;
    if (empty !== 1'b1) $display("FAIL midreset_empty: got %b, required 1", empty); else passes++;
    if (overflow !== 1'b0) $display("FAIL midreset_overflow: got %b, required 0", overflow); else passes++;
    if (xfers - x0 != 3) $display("FAIL midreset_partial: got %0d bytes, required 3", xfers - x0); else passes++;
    rst = 1'b0;
    cyc();
    x0 = xfers;
    push_exp(BLK_A);
    blk  = BLK_A;
    done = 1'b1;
    cyc();
    done = 1'b0;
    cyc();
    checks += 2;
    if (bif.byte_valid !== 1'b1) $display("FAIL restart_valid: got %b, required 1", bif.byte_valid); else passes++;
    if (bif.byte_data !== 8'h01) $display("FAIL restart_byte0: got %h, required 01", bif.byte_data); else passes++;
    wait_idle(40);
    for (int i = 0; i < 3; i++) cyc();
    checks++;
    if (xfers - x0 != 8) $display("FAIL restart_count: got %0d bytes, required 8", xfers - x0); else passes++;
  endtask

  initial begin
    bif.byte_ready = 1'b0;
    test_reset();
    test_single();
    test_held_done();
    test_backpressure();
    test_fill();
    test_full_pop();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) $display("FAIL leftover: %0d bytes never seen, required 0", sb.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
